// File: rtl/spi_router_pkg.sv
// Shared definitions for the SPI target router: state encoding, parameter ranges and
// the lowest-set-bit helper used by the selector.
package spi_router_pkg;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StActive  = 2'd1;
    localparam logic [1:0] StRelease = 2'd2;

    localparam int unsigned NChMin    = 2;
    localparam int unsigned NChMax    = 8;
    localparam int unsigned CsFiltMin = 1;
    localparam int unsigned CsFiltMax = 15;
    localparam int unsigned TurnMax   = 7;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [NChMax-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NChMax - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_cs_filter.sv
// Per-channel chip-select conditioning: 2-FF synchroniser followed by a low-run counter
// that reports the channel asserted after CsFilt consecutive low samples.
module spi_cs_filter
    import spi_router_pkg::*;
#(
    parameter int unsigned CsFilt = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n_i,
    output logic cs_sync_o,
    output logic asserted_o
);

    localparam int unsigned CntW = $clog2(CsFiltMax + 1);

    logic [1:0]      sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], cs_n_i};
        cnt_d  = cnt_q;
        if (sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CntW'(CsFilt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser resets to the idle (high) level so reset never looks like a selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cs_sync_o  = sync_q[1];
    assign asserted_o = (cnt_q == CntW'(CsFilt));

endmodule

// File: rtl/spi_target_router.sv
// Routes one shared SPI bus to N_CH chip-select-qualified targets through a registered
// selector. Optional conflict event counter enabled by define SPI_ROUTER_ERRCNT_EN.
module spi_target_router
    import spi_router_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CS_FILT = 2,
    parameter int unsigned TURN    = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso_o,
    output logic             spi_miso_oe,
    input  logic [N_CH-1:0]  tgt_cs_n,
    output logic [N_CH-1:0]  tgt_mosi,
    input  logic [N_CH-1:0]  tgt_miso,
    output logic [2:0]       active_ch,
    output logic             busy,
    output logic             conflict,
    output logic             frame_done,
`ifdef SPI_ROUTER_ERRCNT_EN
    output logic [7:0]       conflict_cnt,
`endif
    output logic [CNT_W-1:0] frame_bits
);

    logic [N_CH-1:0]   cs_sync;
    logic [N_CH-1:0]   asserted;
    logic [NChMax-1:0] asserted_pad;
    logic [N_CH-1:0]   active_oh;
    logic [N_CH-1:0]   new_assert;
    logic              multi_assert;
    logic              sclk_rise;
    logic              conflict_ev;

    logic [1:0]       state_q, state_d;
    logic [2:0]       active_ch_q, active_ch_d;
    logic             conflict_q, conflict_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_bits_q, frame_bits_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       turn_cnt_q, turn_cnt_d;
    logic [N_CH-1:0]  asserted_prev_q, asserted_prev_d;
    logic [2:0]       sclk_sync_q, sclk_sync_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_filter
        spi_cs_filter #(
            .CsFilt (CS_FILT)
        ) u_filter (
            .clk        (clk),
            .rst        (rst),
            .cs_n_i     (tgt_cs_n[g]),
            .cs_sync_o  (cs_sync[g]),
            .asserted_o (asserted[g])
        );
    end

    always_comb begin
        active_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            active_oh[i] = (active_ch_q == 3'(i));
        end
    end

    assign asserted_pad = NChMax'(asserted);
    assign multi_assert = |(asserted & (asserted - 1'b1));
    // Only a fresh assertion on a non-selected channel counts as a new conflict event.
    assign new_assert   = asserted & ~asserted_prev_q & ~active_oh;
    assign sclk_rise    = sclk_sync_q[1] & ~sclk_sync_q[2];

    always_comb begin
        state_d         = state_q;
        active_ch_d     = active_ch_q;
        frame_done_d    = 1'b0;
        frame_bits_d    = frame_bits_q;
        bit_cnt_d       = bit_cnt_q;
        turn_cnt_d      = turn_cnt_q;
        conflict_ev     = 1'b0;
        asserted_prev_d = asserted;
        sclk_sync_d     = {sclk_sync_q[1:0], spi_sclk};

        case (state_q)
            StIdle: begin
                if (|asserted) begin
                    active_ch_d = lowest_set(asserted_pad);
                    bit_cnt_d   = '0;
                    state_d     = StActive;
                    conflict_ev = multi_assert;
                end
            end
            StActive: begin
                if (sclk_rise && (bit_cnt_q != '1)) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                conflict_ev = |new_assert;
                if (|(cs_sync & active_oh)) begin
                    state_d      = StRelease;
                    frame_bits_d = bit_cnt_q;
                    frame_done_d = 1'b1;
                    turn_cnt_d   = '0;
                end
            end
            StRelease: begin
                // TURN=0 still spends one cycle here.
                if (32'(turn_cnt_q) + 32'd1 >= TURN) begin
                    state_d = StIdle;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        conflict_d = conflict_q | conflict_ev;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            active_ch_q     <= '0;
            conflict_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_bits_q    <= '0;
            bit_cnt_q       <= '0;
            turn_cnt_q      <= '0;
            asserted_prev_q <= '0;
            sclk_sync_q     <= '0;
        end else begin
            state_q         <= state_d;
            active_ch_q     <= active_ch_d;
            conflict_q      <= conflict_d;
            frame_done_q    <= frame_done_d;
            frame_bits_q    <= frame_bits_d;
            bit_cnt_q       <= bit_cnt_d;
            turn_cnt_q      <= turn_cnt_d;
            asserted_prev_q <= asserted_prev_d;
            sclk_sync_q     <= sclk_sync_d;
        end
    end

`ifdef SPI_ROUTER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (conflict_ev && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign conflict_cnt = err_cnt_q;
`endif

    assign busy        = (state_q == StActive);
    assign spi_miso_oe = busy;
    assign spi_miso_o  = busy & |(tgt_miso & active_oh);
    assign tgt_mosi    = busy ? (active_oh & {N_CH{spi_mosi}}) : '0;
    assign active_ch   = active_ch_q;
    assign conflict    = conflict_q;
    assign frame_done  = frame_done_q;
    assign frame_bits  = frame_bits_q;

endmodule

// File: tb/tb_spi_target_router.sv
// Directed bench for spi_target_router (N_CH=4, CS_FILT=2, TURN=3): routing table plus
// hand-written frame, glitch, turnaround, reset and conflict sequences.
module tb_spi_target_router;

    localparam int N_CH    = 4;
    localparam int CS_FILT = 2;
    localparam int TURN    = 3;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso_o;
    logic             spi_miso_oe;
    logic [N_CH-1:0]  tgt_cs_n;
    logic [N_CH-1:0]  tgt_mosi;
    logic [N_CH-1:0]  tgt_miso;
    logic [2:0]       active_ch;
    logic             busy;
    logic             conflict;
    logic             frame_done;
    logic [CNT_W-1:0] frame_bits;
`ifdef SPI_ROUTER_ERRCNT_EN
    logic [7:0]       conflict_cnt;
`endif

    spi_target_router #(
        .N_CH    (N_CH),
        .CS_FILT (CS_FILT),
        .TURN    (TURN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso_o  (spi_miso_o),
        .spi_miso_oe (spi_miso_oe),
        .tgt_cs_n    (tgt_cs_n),
        .tgt_mosi    (tgt_mosi),
        .tgt_miso    (tgt_miso),
        .active_ch   (active_ch),
        .busy        (busy),
        .conflict    (conflict),
        .frame_done  (frame_done),
`ifdef SPI_ROUTER_ERRCNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .frame_bits  (frame_bits)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mosi;
        logic [3:0] miso;
        logic [3:0] exp_tmosi;
        logic       exp_miso;
    } vec_t;

    vec_t vecs[6];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks and land 1 ns after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int maxc, output int took);
        took = 0;
        while (busy !== 1'b1 && took < maxc) begin
            cyc(1);
            took++;
        end
    endtask

    task automatic wait_done(input int maxc, output int took);
        took = 0;
        while (frame_done !== 1'b1 && took < maxc) begin
            cyc(1);
            took++;
        end
    endtask

    task automatic sclk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            spi_sclk = 1'b1;
            cyc(4);
            spi_sclk = 1'b0;
            cyc(4);
        end
    endtask

    initial begin
        int  took;
        int  oe_low;
        logic seen_busy, seen_done;

        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{1'b1, 4'b0000, 4'b0100, 1'b0};
        vecs[2] = '{1'b1, 4'b0100, 4'b0100, 1'b1};
        vecs[3] = '{1'b0, 4'b1011, 4'b0000, 1'b0};
        vecs[4] = '{1'b0, 4'b1111, 4'b0000, 1'b1};
        vecs[5] = '{1'b1, 4'b1011, 4'b0100, 1'b0};

        // Reset state, with live inputs that would show through a faulty mux.
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b1;
        tgt_miso = 4'hF;
        tgt_cs_n = 4'hF;
        cyc(3);
        check("rst_busy", busy, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_miso", spi_miso_o, 0);
        check("rst_tmosi", tgt_mosi, 0);
        check("rst_active_ch", active_ch, 0);
        check("rst_conflict", conflict, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_bits", frame_bits, 0);

        // Frame on channel 2: latency, routing table, 16 SCLK edges.
        rst      = 1'b0;
        spi_mosi = 1'b0;
        tgt_miso = 4'h0;
        cyc(2);
        tgt_cs_n[2] = 1'b0;
        wait_busy(8, took);
        check("sel_latency_le5", (busy === 1'b1) && (took <= 5), 1);
        check("sel_active_ch", active_ch, 2);
        check("sel_oe", spi_miso_oe, 1);
        for (int i = 0; i < 6; i++) begin
            spi_mosi = vecs[i].mosi;
            tgt_miso = vecs[i].miso;
            #1;
            check($sformatf("vec%0d_tmosi", i), tgt_mosi, vecs[i].exp_tmosi);
            check($sformatf("vec%0d_miso", i), spi_miso_o, vecs[i].exp_miso);
            cyc(1);
        end
        spi_mosi = 1'b0;
        tgt_miso = 4'h0;
        sclk_pulses(16);
        tgt_cs_n[2] = 1'b1;
        wait_done(8, took);
        check("desel_latency", took, 3);
        check("desel_busy", busy, 0);
        check("desel_oe", spi_miso_oe, 0);
        check("frame16_bits", frame_bits, 16);
        check("frame16_conflict", conflict, 0);
        cyc(1);
        check("frame_done_pulse", frame_done, 0);

        // One-clock glitch on CS[0] must be filtered out.
        cyc(6);
        tgt_cs_n[0] = 1'b0;
        cyc(1);
        tgt_cs_n[0] = 1'b1;
        seen_busy = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            seen_busy |= busy;
            seen_done |= frame_done;
        end
        check("glitch_busy", seen_busy, 0);
        check("glitch_done", seen_done, 0);

        // Back-to-back: CS[0] frame then CS[2]; MISO OE low for TURN+1 clocks.
        tgt_cs_n[0] = 1'b0;
        wait_busy(8, took);
        check("b2b_first_ch", active_ch, 0);
        sclk_pulses(3);
        tgt_cs_n[0] = 1'b1;
        tgt_cs_n[2] = 1'b0;
        took = 0;
        while (spi_miso_oe === 1'b1 && took < 10) begin
            cyc(1);
            took++;
        end
        oe_low = 0;
        while (spi_miso_oe !== 1'b1 && oe_low < 20) begin
            cyc(1);
            oe_low++;
        end
        check("b2b_oe_low_clks", oe_low, 4);
        check("b2b_second_ch", active_ch, 2);
        check("b2b_first_bits", frame_bits, 3);
        check("b2b_conflict", conflict, 0);
        sclk_pulses(1);
        tgt_cs_n[2] = 1'b1;
        wait_done(8, took);
        check("b2b_second_bits", frame_bits, 1);

        // Reset mid-frame with CS[1] held low; reselect and count 5 fresh edges.
        cyc(6);
        tgt_cs_n[1] = 1'b0;
        wait_busy(8, took);
        check("rstmid_sel_ch", active_ch, 1);
        sclk_pulses(2);
        spi_mosi = 1'b1;
        tgt_miso = 4'b0010;
        rst = 1'b1;
        cyc(1);
        check("rstmid_busy", busy, 0);
        check("rstmid_oe", spi_miso_oe, 0);
        check("rstmid_miso", spi_miso_o, 0);
        check("rstmid_tmosi", tgt_mosi, 0);
        check("rstmid_active_ch", active_ch, 0);
        check("rstmid_frame_bits", frame_bits, 0);
        rst      = 1'b0;
        spi_mosi = 1'b0;
        tgt_miso = 4'h0;
        wait_busy(8, took);
        check("rstmid_reselect", (busy === 1'b1) && (took <= 5), 1);
        check("rstmid_reselect_ch", active_ch, 1);
        sclk_pulses(5);
        tgt_cs_n[1] = 1'b1;
        wait_done(8, took);
        check("rstmid_done_seen", frame_done, 1);
        check("rstmid_bits", frame_bits, 5);

        // Simultaneous CS[1] and CS[3]: lowest wins, sticky conflict.
        cyc(6);
        tgt_cs_n = 4'b0101;
        wait_busy(8, took);
        check("sim_active_ch", active_ch, 1);
        check("sim_conflict", conflict, 1);
`ifdef SPI_ROUTER_ERRCNT_EN
        check("sim_conflict_cnt", conflict_cnt, 1);
`endif
        sclk_pulses(1);
        tgt_cs_n = 4'hF;
        wait_done(8, took);
        cyc(2);
        check("sim_conflict_sticky", conflict, 1);
        check("sim_busy_after", busy, 0);

`ifdef SPI_ROUTER_ERRCNT_EN
        // 300 conflict events while CS[0] is selected; counter saturates.
        cyc(6);
        tgt_cs_n[0] = 1'b0;
        wait_busy(8, took);
        for (int i = 0; i < 300; i++) begin
            tgt_cs_n[1] = 1'b0;
            cyc(4);
            tgt_cs_n[1] = 1'b1;
            cyc(3);
            if (i == 9) check("errcnt_after10", conflict_cnt, 11);
        end
        check("errcnt_saturated", conflict_cnt, 255);
        check("errcnt_ch_kept", active_ch, 0);
        tgt_cs_n = 4'hF;
        cyc(10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_target_router.md
# spi_target_router

Parametrised successor to the fixed FPGA/FIFO/EEPROM SPI data mux. It routes one shared SPI bus (MOSI in, MISO out through an external tristate) to N_CH chip-select-qualified targets. A registered selector is used in place of live combinational CS decode. It adds CS synchronisation and filtering, a selection state machine, conflict detection, MISO turnaround and per-frame bit counting. It sits between the board SPI pins and the on-FPGA/off-FPGA SPI targets.

## Interface
- N_CH, 4: number of targets, 2..8.
- CS_FILT, 2: consecutive clk samples a CS must hold low before selection, 1..15.
- TURN, 1: clk cycles MISO output-enable stays deasserted after release before a new selection, 0..7.
- CNT_W, 16: width of frame bit counter.
- clk  in  1  system clock; all control logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  bus SCLK (asynchronous to clk; synchronised for counting only).
- spi_mosi  in  1  bus MOSI.
- spi_miso_o  out  1  MISO value to pad IOBUF I.
- spi_miso_oe  out  1  1 = drive MISO pad (IOBUF T = ~spi_miso_oe).
- tgt_cs_n  in  N_CH  per-target active-low chip selects.
- tgt_mosi  out  N_CH  per-target MOSI; 0 when not selected.
- tgt_miso  in  N_CH  per-target MISO.
- active_ch  out  3  index of selected target; valid when busy.
- busy  out  1  a target is selected.
- conflict  out  1  sticky: more than one filtered CS seen low; cleared by rst only.
- frame_done  out  1  one-clk pulse at end of a frame.
- frame_bits  out  CNT_W  SCLK rising edges counted in the last completed frame.

## Operation
- Each tgt_cs_n bit passes a 2-FF synchroniser, then a CS_FILT-deep low-run counter; a channel is "asserted" once its synchronised CS has been low for CS_FILT consecutive samples. A single high sample resets that channel's counter.
- States: IDLE, ACTIVE, RELEASE.
- IDLE: if any channel is asserted, latch the lowest asserted index into active_ch and go to ACTIVE. If two or more channels are asserted in the same cycle, set conflict.
- ACTIVE: busy=1, spi_miso_oe=1, spi_miso_o=tgt_miso[active_ch], tgt_mosi[active_ch]=spi_mosi, other tgt_mosi=0. The data paths are combinational through the registered selector; they are never resampled.
  - Count rising edges of synchronised spi_sclk, saturating at all-ones.
  - Any other channel becoming asserted sets conflict; the selection is unchanged.
  - When synchronised tgt_cs_n[active_ch] reads high, go to RELEASE, copy the count to frame_bits, and pulse frame_done.
- RELEASE: busy=0, spi_miso_oe=0, all tgt_mosi=0. Hold TURN cycles, then go to IDLE. With TURN=0, RELEASE lasts exactly one cycle.
- Counter clears on entry to ACTIVE.

## Timing
- Reset values: state IDLE, spi_miso_oe=0, spi_miso_o=0, tgt_mosi=0, active_ch=0, busy=0, conflict=0, frame_done=0, frame_bits=0, all filter counters 0.
- Selection latency:
  - A CS falling before clk edge k becomes synchronised at edge k+2.
  - The channel is asserted after CS_FILT further samples.
  - busy rises on the following edge: k+2+CS_FILT+1 worst case.
- Deselection: busy falls 3 clk after the CS rise (2 sync + 1 state), together with the frame_done pulse.
- rst asserted mid-frame returns to reset values on the next edge. A CS still held low is re-filtered and reselected after rst deasserts, and that frame's count restarts.
- Counting is valid only if the SCLK high and low phases are each ≥ 2 clk periods.

## Configuration
- SPI_ROUTER_ERRCNT_EN defined: adds output conflict_cnt (8 bits), incremented once per conflict-setting event, saturating at 255, reset to 0.
- SPI_ROUTER_ERRCNT_EN undefined: port and counter absent; conflict flag unchanged.

## Structure
- Shared package spi_router_pkg: state encoding (IDLE/ACTIVE/RELEASE), parameter legal-range constants, and a function returning the lowest set bit index of an N_CH vector.
- One sub-module: spi_cs_filter, one instance per channel (2-FF sync plus low-run counter, output asserted). The top holds the FSM, data muxing and counters.

## Test plan
- N_CH=4, CS_FILT=2: tgt_cs_n[2] low, 16 SCLK cycles at clk/8, CS high → busy within 5 clk, MOSI seen only on tgt_mosi[2], spi_miso_o follows tgt_miso[2], frame_done pulse, frame_bits=16.
- Simultaneous CS[1] and CS[3] low → active_ch=1, conflict=1 and stays 1 after the frame ends.
- 1-clk low glitch on CS[0] with CS_FILT=2 → busy stays 0, no frame_done.
- TURN=3, back-to-back frames on CS[0] then CS[2] → spi_miso_oe low for exactly 4 clk between frames.
- rst pulse mid-frame with CS[1] held low → all outputs at reset values; reselection after rst, and a frame of 5 further SCLK rising edges gives frame_bits=5.
- SPI_ROUTER_ERRCNT_EN defined: 300 conflict events → conflict_cnt=255.
